// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for scan_decoder: FSM states, mode encodings and
// the polarity-aware one-cold/one-hot decode.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest select the decode helper supports; callers slice the low 2**SEL_W bits.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  // One-hot decode of sel, inverted to one-cold when active_low is set.
  function automatic logic [MAX_OUT_W-1:0] decode_onecold(input logic [MAX_SEL_W-1:0] sel,
                                                          input logic                 active_low);
    logic [MAX_OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/scan_decoder_dwell.sv
// dwell_timer: free-running 0..DWELL-1 counter with synchronous clear.
// tick_o flags the last cycle of a window; cnt_nxt_o is the count the
// window will hold after the coming edge, so registered consumers can act on it.
module dwell_timer
  import scan_decoder_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          tick_o,
  output logic [CW-1:0] cnt_nxt_o
);

  localparam logic [CW-1:0] TOP = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at TOP or increment.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == TOP) cnt_d = '0;
  end

  assign tick_o    = (cnt_q == TOP);
  assign cnt_nxt_o = cnt_d;

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N select decoder with a built-in channel
// scanner. DIRECT decodes `a` with one cycle of latency; SCAN walks channels
// 0..last, holding each for DWELL cycles and pulsing `wrap` on each return to 0.
// Optional macro SCAN_DECODER_BLANK_EN blanks Y for the first BLANK_CYC cycles
// of every scan window (ghosting dead-time).
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL      = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      a,
  input  logic [SEL_W-1:0]      last,
  output logic [(2**SEL_W)-1:0] Y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int              OUT_W = 2 ** SEL_W;
  localparam int              CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [OUT_W-1:0] INACT = (ACTIVE_LOW != 0) ? '1 : '0;

  state_e             state_q, ns;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               timer_clr, tick;
  logic [CW-1:0]      cnt_nxt;
  logic [MAX_SEL_W-1:0] sel_ext;
  logic [MAX_OUT_W-1:0] dec_full;

  // Mode decode: state follows en/mode every cycle.
  always_comb begin
    ns = IDLE;
    if (en) ns = (mode == MODE_SCAN) ? SCAN : DIRECT;
  end

  // Counter runs only while staying in SCAN; entry (or any other state) clears it,
  // so channel 0 always gets a full window after entering SCAN.
  assign timer_clr = (ns != SCAN) || (state_q != SCAN);

  dwell_timer #(.DWELL(DWELL), .CW(CW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (timer_clr),
    .tick_o   (tick),
    .cnt_nxt_o(cnt_nxt)
  );

  // Next idx/wrap/Y; a mode change overrides a coincident dwell expiry.
  always_comb begin
    idx_d    = '0;
    wrap_d   = 1'b0;
    y_d      = INACT;
    sel_ext  = '0;
    dec_full = '0;
    case (ns)
      DIRECT: idx_d = a;
      SCAN: begin
        if (!timer_clr) begin
          idx_d = idx_q;
          if (tick) begin
            // >= also catches `last` having dropped below the current channel.
            if (idx_q >= last) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
    sel_ext[SEL_W-1:0] = idx_d;
    dec_full           = decode_onecold(sel_ext, ACTIVE_LOW != 0);
    if (ns != IDLE) y_d = dec_full[OUT_W-1:0];
`ifdef SCAN_DECODER_BLANK_EN
    if (ns == SCAN && cnt_nxt < CW'(BLANK_CYC)) y_d = INACT;
`endif
  end

`ifndef SCAN_DECODER_BLANK_EN
  logic unused_cnt;
  assign unused_cnt = ^cnt_nxt;
`endif

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= INACT;
    end else begin
      state_q <= ns;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign Y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder (SEL_W=3, DWELL=4, BLANK_CYC=1, ACTIVE_LOW=1).
// A behavioural model tracks channel/window age and is compared every cycle;
// directed phases add literal expectations, then random en/mode/a/last traffic.
module tb_scan_decoder;

  localparam int DWELL = 4;
  localparam int BLANK_CYC = 1;
`ifdef SCAN_DECODER_BLANK_EN
  localparam bit BLANKING = 1'b1;
`else
  localparam bit BLANKING = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, mode;
  logic [2:0] a, last;
  logic [7:0] Y;
  logic [2:0] idx;
  logic       wrap;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  scan_decoder #(.SEL_W(3), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .last(last),
    .Y(Y), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec(input int ch);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << ch);
  endfunction

  // Behavioural model: which channel is shown, how long the current window has run.
  int         m_idx = 0, m_age = 0;
  bit         m_scan = 0, m_on = 0, m_wrap = 0;
  logic [7:0] m_y = 8'hFF;

  always @(posedge clk or negedge rst_n) begin
    m_wrap = 0;
    if (!rst_n) begin
      m_idx = 0; m_age = 0; m_scan = 0; m_on = 0;
    end else if (!en) begin
      m_idx = 0; m_scan = 0; m_on = 0;
    end else if (!mode) begin
      m_idx = int'(a); m_scan = 0; m_on = 1;
    end else if (!m_scan) begin
      m_idx = 0; m_age = 0; m_scan = 1; m_on = 1;
    end else begin
      m_age = m_age + 1;
      if (m_age == DWELL) begin
        m_age = 0;
        if (m_idx >= int'(last)) begin m_idx = 0; m_wrap = 1; end
        else m_idx = m_idx + 1;
      end
    end
    if (!m_on) m_y = 8'hFF;
    else if (m_scan && BLANKING && m_age < BLANK_CYC) m_y = 8'hFF;
    else m_y = dec(m_idx);
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_Y", Y, m_y);
      chk("model_idx", idx, m_idx[2:0]);
      chk("model_wrap", wrap, m_wrap);
    end
  end

  initial begin
    logic [7:0] exp_y;
    bit found;
    int nwrap;
    rst_n = 0; en = 0; mode = 0; a = 0; last = 0;
    repeat (3) @(negedge clk);
    chk("rst_Y", Y, 8'hFF);
    chk("rst_idx", idx, 0);
    chk("rst_wrap", wrap, 0);
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("idle_Y", Y, 8'hFF);

    // DIRECT sweep
    en = 1; mode = 0;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      @(negedge clk);
      case (i)
        0: exp_y = 8'hFE; 1: exp_y = 8'hFD; 2: exp_y = 8'hFB; 3: exp_y = 8'hF7;
        4: exp_y = 8'hEF; 5: exp_y = 8'hDF; 6: exp_y = 8'hBF; default: exp_y = 8'h7F;
      endcase
      chk("direct_Y", Y, exp_y);
      chk("direct_idx", idx, i);
    end
    en = 0;
    @(negedge clk);
    chk("en_off_Y", Y, 8'hFF);

    // SCAN wrap with last=2
    en = 1; mode = 1; last = 2;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("scan_idx", idx, (c / 4) % 3);
      chk("scan_wrap", wrap, (c == 12) ? 1 : 0);
      exp_y = (BLANKING && (c % 4) == 0) ? 8'hFF : dec((c / 4) % 3);
      chk("scan_Y", Y, exp_y);
    end

    // last shrink while on channel 5
    last = 7;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (idx == 3'd5) found = 1;
    end
    chk("reach_idx5", found, 1);
    last = 3;
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (idx != 3'd5) found = 1;
    end
    chk("shrink_advance", found, 1);
    chk("shrink_idx", idx, 0);
    chk("shrink_wrap", wrap, 1);

    // Mode switch DIRECT(6) -> SCAN
    mode = 0; a = 6;
    @(negedge clk);
    chk("ms_direct_idx", idx, 6);
    chk("ms_direct_Y", Y, 8'hBF);
    mode = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("ms_idx", idx, 0);
      chk("ms_Y", Y, (BLANKING && c == 0) ? 8'hFF : 8'hFE);
    end
    @(negedge clk);
    chk("ms_next_idx", idx, 1);

    // Asynchronous reset mid-scan
    #2 rst_n = 0;
    #1;
    chk("arst_Y", Y, 8'hFF);
    chk("arst_idx", idx, 0);
    chk("arst_wrap", wrap, 0);
    @(negedge clk);
    rst_n = 1;

    // last=0 holds channel 0, wrap every DWELL cycles
    last = 0;
    nwrap = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("last0_idx", idx, 0);
      if (wrap) nwrap++;
    end
    chk("last0_wraps", nwrap, 3);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      a = 3'($urandom_range(0, 7));
      if (en ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0)) en = ~en;
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 24) == 0) last = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 799) == 0) begin
        #2 rst_n = 0;
        #1 chk("rnd_arst_idx", idx, 0);
        @(negedge clk);
        rst_n = 1;
      end
      @(negedge clk);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised, registered N-to-2^N one-cold decoder with a built-in channel scanner, used as the successor to the 3-to-8 decoder for driving digit or row selects on the board. In DIRECT mode it decodes a select input, as the original decoder does, but registered and with a one-cycle latency. In SCAN mode it steps through channels 0..`last` on its own, holding each for a programmable dwell time, and flags each wrap. It sits between the control logic and the display or matrix select pins.

## Interface
- `SEL_W`, 3: select width; output width is 2**SEL_W.
- `DWELL`, 50000: clock cycles each channel is held in SCAN mode; must be at least 2.
- `BLANK_CYC`, 2: blanking cycles at the start of each scan window; used only with the macro; must be less than DWELL.
- `ACTIVE_LOW`, 1: 1 means the selected line is 0 and the others are 1; 0 inverts this (one-hot).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  enable; 0 forces all outputs inactive.
- `mode`  in  1  0 = DIRECT, 1 = SCAN.
- `a`  in  SEL_W  channel select used in DIRECT mode.
- `last`  in  SEL_W  highest channel visited in SCAN mode.
- `Y`  out  2**SEL_W  registered one-cold (or one-hot) select.
- `idx`  out  SEL_W  channel currently driven.
- `wrap`  out  1  one-cycle pulse when the scan returns from `last` to 0.

## Operation
- FSM states: IDLE, DIRECT, SCAN.
  - IDLE when `en`=0.
  - DIRECT when `en`=1 and `mode`=0.
  - SCAN when `en`=1 and `mode`=1.
  - The next state is evaluated every cycle.
- IDLE:
  - `Y` is all inactive, `idx`=0, `wrap`=0.
  - The dwell counter is cleared.
- DIRECT:
  - `Y` = decode(`a`) and `idx` = `a`, both registered.
  - `wrap`=0. The dwell counter is held at 0.
- SCAN:
  - The dwell counter counts 0..DWELL-1. At DWELL-1 it returns to 0 and `idx` advances.
  - Advance rule: if `idx` >= `last`, then `idx` becomes 0 and `wrap` pulses for one cycle. Otherwise `idx` becomes `idx`+1.
  - `Y` = decode(`idx`).
- Entering SCAN from any other state loads `idx`=0 with the counter at 0. Channel 0 therefore gets a full dwell window.
- Changing `last` mid-scan takes effect at the next advance. If `last` has dropped below `idx`, the next advance wraps to 0.
- `last`=0 holds channel 0 permanently, with `wrap` pulsing once every DWELL cycles.
- Arithmetic: the dwell counter is an unsigned register of width $clog2(DWELL). `idx`+1 is computed in SEL_W bits and cannot overflow because of the >= `last` check.
- Output polarity: `Y` is inverted from one-hot when ACTIVE_LOW=1.

## Timing
- Reset values: `Y` all inactive (all 1 when ACTIVE_LOW=1), `idx`=0, `wrap`=0, FSM in IDLE, counter 0.
- Reset asserted mid-scan clears everything immediately, asynchronously. Operation resumes at the first rising edge after `rst_n` deasserts.
- DIRECT latency: `a` sampled at edge k appears on `Y` and `idx` after edge k.
- `en` falling: `Y` is inactive after the next edge.
- `en` rising with `mode`=1: channel 0 drives `Y` after the first edge, for DWELL cycles. Channel 1 follows after edge DWELL+1.
- `wrap` is asserted in the same cycle that `idx` first shows 0 after `last`.
- Simultaneous mode change and dwell expiry: the mode change wins.
- All outputs are registered, with no combinational path from the inputs.

## Configuration
- Macro: `SCAN_DECODER_BLANK_EN`.
- Defined: in SCAN mode, `Y` is forced all-inactive for the first BLANK_CYC cycles of every dwell window, including the entry window. This provides ghosting dead-time.
  - `idx` and `wrap` timing are unchanged.
  - DIRECT mode is unaffected.
- Undefined: no blanking. BLANK_CYC is ignored and the blanking logic is not synthesised.

## Structure
- Shared package `scan_decoder_pkg` holds:
  - the state enum (IDLE, DIRECT, SCAN);
  - the mode constants MODE_DIRECT=0 and MODE_SCAN=1;
  - a `decode_onecold` function parametrised by polarity.
- One sub-module, `dwell_timer`:
  - counts to DWELL-1 and emits a one-cycle `tick`;
  - has synchronous clear, driven on state entry;
  - exposes its count value for the blanking compare.
- The top level contains the FSM, the `idx` register, the decode, and the output registers.

## Test plan
All scenarios use SEL_W=3, DWELL=4, BLANK_CYC=1, ACTIVE_LOW=1.
- Reset: assert `rst_n`=0 mid-scan -> `Y`=8'hFF, `idx`=0, `wrap`=0 immediately, asynchronously.
- DIRECT sweep: `en`=1, `mode`=0, `a`=0..7 on consecutive cycles -> `Y` = 8'hFE, FD, FB, F7, EF, DF, BF, 7F, each one cycle after its `a`. Then `en`=0 -> 8'hFF next cycle.
- SCAN wrap: `mode`=1, `last`=2 -> `idx` sequence 0,1,2,0 with 4 cycles each. `wrap`=1 only in the first cycle of the second visit to channel 0, then every 12 cycles.
- `last` shrink: while `idx`=5, set `last`=3 -> next advance gives `idx`=0 and `wrap`=1.
- Mode switch: DIRECT with `a`=6, then `mode`=1 -> `idx`=0 after the next edge, `Y`=8'hFE for 4 cycles.
- Blanking, with the macro defined: in SCAN, `Y`=8'hFF in the first cycle of each window and the decoded value for the remaining 3 cycles. Without the macro, there are no 8'hFF cycles.
